// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants, FSM state type and group-index width helper for FC1
package bnn_pkg;

  localparam int BNN_IN_W    = 784;
  localparam int BNN_HIDDEN  = 256;
  localparam int BNN_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Width of the group index; never narrower than one bit even for a single group.
  function automatic int grp_w(input int n_neurons, input int lanes);
    int ngrp;
    ngrp = n_neurons / lanes;
    return (ngrp > 1) ? $clog2(ngrp) : 1;
  endfunction

endpackage

// File: rtl/bnn_seq_collector.sv
// rtl/bnn_seq_collector.sv - return counter and MSB-first slot writes of lane results into the hidden vector
module bnn_seq_collector
  import bnn_pkg::*;
#(
  parameter int N_NEURONS = BNN_HIDDEN,
  parameter int LANES     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 lane_valid_i,
  input  logic [LANES-1:0]     lane_result_i,
  output logic                 full_o,
  output logic [N_NEURONS-1:0] result_o
);

  localparam int NGRP  = N_NEURONS / LANES;
  localparam int CNT_W = $clog2(NGRP + 1);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_NEURONS-1:0] result_q, result_d;
  logic                 wr;

  // Writes stop once every group has returned, so extra returns are dropped.
  assign wr = en_i && lane_valid_i && (cnt_q != CNT_W'(NGRP));

  // Full reflects the count after this cycle's return so the FSM can leave on the final return.
  assign full_o   = (cnt_d == CNT_W'(NGRP));
  assign result_o = result_q;

  // Next count and slot write: lane j of group r lands on bit N_NEURONS-1-(r*LANES+j).
  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr) begin
      cnt_d = cnt_q + 1'b1;
      for (int g = 0; g < NGRP; g++) begin
        if (int'(cnt_q) == g) begin
          for (int j = 0; j < LANES; j++) begin
            result_d[N_NEURONS-1-(g*LANES+j)] = lane_result_i[j];
          end
        end
      end
    end
  end

  // Counter and hidden-vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: rtl/bnn_fc1_sequencer.sv
// rtl/bnn_fc1_sequencer.sv - group-serial FC1 sequencer; BNN_SEQ_PERF_EN adds the o_frame_cycles counter
module bnn_fc1_sequencer
  import bnn_pkg::*;
#(
  parameter int  IN_W      = BNN_IN_W,
  parameter int  N_NEURONS = BNN_HIDDEN,
  parameter int  LANES     = 16,
  localparam int NGRP      = N_NEURONS / LANES,
  localparam int GRP_W     = grp_w(N_NEURONS, LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [IN_W-1:0]      i_data,
  output logic                 o_grp_valid,
  output logic [GRP_W-1:0]     o_grp_idx,
  output logic [IN_W-1:0]      o_frame,
  input  logic                 i_lane_valid,
  input  logic [LANES-1:0]     i_lane_result,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N_NEURONS-1:0] o_result
`ifdef BNN_SEQ_PERF_EN
  ,
  output logic [15:0]          o_frame_cycles
`endif
);

  seq_state_e       state_q, state_d;
  logic [GRP_W-1:0] issue_q, issue_d;
  logic [IN_W-1:0]  frame_q, frame_d;
  logic             rdy_q;
  logic             take, clr, col_en, col_full;

  // i_ready is registered so it stays low while reset is held.
  assign take      = rdy_q && i_valid;
  assign i_ready   = rdy_q;
  assign o_frame   = frame_q;
  assign o_grp_idx = issue_q;

  bnn_seq_collector #(
    .N_NEURONS (N_NEURONS),
    .LANES     (LANES)
  ) u_coll (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (clr),
    .en_i          (col_en),
    .lane_valid_i  (i_lane_valid),
    .lane_result_i (i_lane_result),
    .full_o        (col_full),
    .result_o      (o_result)
  );

  // Next state, issue counter, frame capture and handshake strobes.
  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    frame_d     = frame_q;
    clr         = 1'b0;
    col_en      = 1'b0;
    o_grp_valid = 1'b0;
    o_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          frame_d = i_data;
          clr     = 1'b1;
          issue_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        o_grp_valid = 1'b1;
        col_en      = 1'b1;
        if (issue_q == GRP_W'(NGRP - 1)) begin
          issue_d = '0;
          state_d = col_full ? DONE : DRAIN;
        end else begin
          issue_d = issue_q + 1'b1;
        end
      end
      DRAIN: begin
        col_en = 1'b1;
        if (col_full) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, issue counter, latched frame and ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      issue_q <= '0;
      frame_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      frame_q <= frame_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

`ifdef BNN_SEQ_PERF_EN
  logic [15:0] cyc_q, cyc_d, perf_q, perf_d;

  assign o_frame_cycles = perf_q;

  // Count from the capture cycle (counted as 1) through the cycle before DONE, saturating.
  always_comb begin
    cyc_d  = cyc_q;
    perf_d = perf_q;
    if (state_q == IDLE) begin
      if (take) cyc_d = 16'd1;
    end else if (state_q == ISSUE || state_q == DRAIN) begin
      cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
      if (state_d == DONE) perf_d = cyc_d;
    end
  end

  // Frame cycle counter and latched result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      perf_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      perf_q <= perf_d;
    end
  end
`else
  // No frame cycle counter in this build.
`endif

endmodule

// File: doc/bnn_fc1_sequencer.md
Name: bnn_fc1_sequencer

Overview:
- Time-multiplexes a bank of LANES binary-neuron engines (XNOR-popcount-threshold) across the N_NEURONS hidden neurons of FC1.
- Replaces the fully parallel 256-instance FC1 with a group-serial schedule.
- Accepts one input frame by valid/ready handshake, issues neuron groups, and assembles lane results into the hidden vector.
- Presents the hidden vector to the FC2 stage with valid/ready.

Parameters:
- IN_W, 784, input frame width in bits (one bit per pixel).
- N_NEURONS, 256, FC1 output neurons; must be an exact multiple of LANES.
- LANES, 16, parallel neuron engines; NGRP = N_NEURONS/LANES; GRP_W = max(1, clog2(NGRP)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input frame valid.
- i_ready  out  1  sequencer can accept a frame.
- i_data  in  IN_W  binarized input frame.
- o_grp_valid  out  1  group issue strobe to the lane bank.
- o_grp_idx  out  GRP_W  group index; the lane bank uses it as the weight/threshold ROM address.
- o_frame  out  IN_W  latched frame broadcast to all lanes.
- i_lane_valid  in  1  lane bank returns results of one group.
- i_lane_result  in  LANES  bit j = neuron (group*LANES + j) output.
- o_valid  out  1  hidden vector valid.
- o_ready  in  1  FC2 stage accepts the vector.
- o_result  out  N_NEURONS  hidden vector; neuron k at bit N_NEURONS-1-k (MSB-first).

Behaviour:
- Reset values: i_ready=0 during reset, 1 in IDLE afterwards. o_grp_valid=0, o_grp_idx=0, o_frame=0, o_valid=0, o_result=0. Issue and return counters are 0, state is IDLE.
- FSM IDLE: i_ready=1. On i_valid, capture i_data into o_frame, clear the return counter, go to ISSUE.
- FSM ISSUE: o_grp_valid=1 every cycle with o_grp_idx = 0,1,…,NGRP-1 consecutively (no bubbles). After issuing NGRP-1, go to DRAIN. i_ready=0.
- FSM DRAIN: wait until the return count reaches NGRP, then go to DONE.
- FSM DONE: o_valid=1 with o_result stable. On o_valid && o_ready, deassert o_valid and go to IDLE. The next frame is accepted no earlier than the following cycle.
- Return handling: lane results return in issue order. Each i_lane_valid in ISSUE, DRAIN or the transition cycle writes i_lane_result into o_result group slot r = return count. Lane j goes to bit N_NEURONS-1-(r*LANES+j). The return count then increments.
- Lane latency is not a parameter; the sequencer relies only on i_lane_valid. A return may arrive in the same cycle as an issue.
- The ISSUE→DRAIN→DONE transitions are combinational on the counters. If the final return arrives during ISSUE (latency 0), the FSM goes straight to DONE.
- o_frame holds from capture until the next capture, so it is stable for the whole frame.
- i_lane_valid in IDLE or DONE is ignored; o_result is unchanged.
- Return count saturates at NGRP; extra returns are ignored.
- o_ready held low keeps DONE indefinitely with no state change.
- Reset mid-frame aborts immediately: all state returns to reset values and late lane returns after reset are ignored (state is IDLE).
- Latency example (defaults, lane bank returns 2 cycles after issue): handshake at cycle 0, issues at cycles 1–16, last return at cycle 18, o_valid at cycle 19.

Optional Feature:
- Macro BNN_SEQ_PERF_EN.
- When defined, adds output o_frame_cycles[15:0], reset 0. It counts cycles from the capture cycle up to the cycle before o_valid first rises, saturating at 16'hFFFF. It is latched when DONE is entered and held until the next latch.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package bnn_pkg holds:
  - Constants BNN_IN_W=784, BNN_HIDDEN=256, BNN_CLASSES=10.
  - The FSM state enum (IDLE, ISSUE, DRAIN, DONE).
  - A function computing GRP_W.
- Sub-module bnn_seq_collector holds the return counter and the slot writes into the MSB-first hidden vector, with a clear strobe and a full flag.

Test Plan:
- Single frame, default params, lane model with latency 2 returning i_lane_result = group index (4 LSBs replicated) → o_grp_idx 0..15 on cycles 1–16, o_valid at cycle 19, o_result[255:240]=16'h0000, o_result[15:0]=16'hFFFF; with PERF, o_frame_cycles=19.
- o_ready held low 10 cycles after o_valid → o_valid and o_result stable, i_ready=0, i_valid frames not captured; on o_ready=1, i_ready=1 the next cycle.
- Back-to-back frames with i_valid always 1 and o_ready always 1 → second capture the cycle after the first o_valid handshake; o_frame for frame 2 equals frame 2 data; no cross-frame bits.
- Lane model latency 0 (same-cycle return) and latency 7 → identical o_result; o_valid at cycles 17 and 24 respectively.
- Spurious i_lane_valid=1, result=16'hFFFF during IDLE and DONE → o_result unchanged, return count unchanged.
- rst_n asserted at cycle 8 of a frame, released at cycle 10 while the lane model still returns → all outputs at reset values, state IDLE, o_valid never asserts, the next frame completes correctly.
